// File: rtl/uart_arb_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int C_NB_REQ     = 2;
  localparam int C_DATA_WIDTH = 8;
  localparam int C_MAX_BURST  = 4;

  // Width of the burst counter; large enough for the biggest allowed burst (255).
  localparam int C_BURST_CW   = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  // Index width for a requester count; keeps a 1-bit index when there is a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first valid requester searching upward from rr_ptr+1, wrapping.
module rr_priority_picker
  import uart_arb_pkg::*;
#(
  parameter  int G_NB_REQ = C_NB_REQ,
  localparam int IDW      = id_width(G_NB_REQ)
) (
  input  logic [G_NB_REQ-1:0] valid_i,
  input  logic [IDW-1:0]      rr_ptr_i,
  output logic [IDW-1:0]      grant_o,
  output logic                any_valid_o
);

  logic [IDW-1:0] cand;

  // Scan the G_NB_REQ positions after the pointer; the pointer itself is checked last.
  always_comb begin
    grant_o     = rr_ptr_i;
    any_valid_o = 1'b0;
    cand        = '0;
    for (int i = 1; i <= G_NB_REQ; i++) begin
      cand = IDW'((int'(rr_ptr_i) + i) % G_NB_REQ);
      if (!any_valid_o && valid_i[cand]) begin
        grant_o     = cand;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requesters onto one UART serializer with round-robin grants
// and a per-grant burst cap.
//
// Requester handshake: a byte moves when i_req_valid[k] and o_req_ready[k] are
// both high in the same cycle. Ready is only ever raised for the granted
// requester, is combinational from its valid and i_tx_busy, and a requester must
// hold valid/data/last stable until it sees ready.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int G_NB_REQ     = C_NB_REQ,
  parameter  int G_DATA_WIDTH = C_DATA_WIDTH,
  parameter  int G_MAX_BURST  = C_MAX_BURST,
  localparam int IDW          = id_width(G_NB_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [G_NB_REQ-1:0]              i_req_valid,
  input  logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_req_data,
  input  logic [G_NB_REQ-1:0]              i_req_last,
  output logic [G_NB_REQ-1:0]              o_req_ready,
  output logic                             o_tx_start,
  output logic [G_DATA_WIDTH-1:0]          o_tx_data,
  input  logic                             i_tx_busy,
  input  logic                             i_tx_done,
  output logic [IDW-1:0]                   o_grant_id,
  output logic                             o_busy,
  output logic                             o_err_done,
  output logic [1:0]                       o_dbg_state
);

  arb_state_e              state_q, state_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic [C_BURST_CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [G_DATA_WIDTH-1:0] data_q, data_d;
  logic                    last_q, last_d;
  logic                    start_q, start_d;
  logic                    err_q, err_d;

  logic [IDW-1:0]          pick_grant;
  logic                    pick_any;
  logic                    g_valid;
  logic                    g_last;
  logic [G_DATA_WIDTH-1:0] g_data;

  rr_priority_picker #(
    .G_NB_REQ(G_NB_REQ)
  ) u_picker (
    .valid_i    (i_req_valid),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (pick_grant),
    .any_valid_o(pick_any)
  );

  // Select only the granted requester's inputs so the others cannot affect anything.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int k = 0; k < G_NB_REQ; k++) begin
      if (grant_q == IDW'(k)) begin
        g_valid = i_req_valid[k];
        g_last  = i_req_last[k];
        g_data  = i_req_data[k*G_DATA_WIDTH +: G_DATA_WIDTH];
      end
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    data_d      = data_q;
    last_d      = last_q;
    start_d     = 1'b0;
    err_d       = err_q;
    o_req_ready = '0;
    case (state_q)
      IDLE: begin
        if (i_tx_done) err_d = 1'b1;
        if (pick_any) begin
          grant_d = pick_grant;
          state_d = SEND;
        end
      end
      SEND: begin
        if (i_tx_done) err_d = 1'b1;
        if (!g_valid) begin
          // Requester went quiet mid-burst: release the grant.
          state_d     = IDLE;
          rr_ptr_d    = grant_q;
          burst_cnt_d = '0;
        end else if (!i_tx_busy) begin
          o_req_ready = G_NB_REQ'(1) << grant_q;
          data_d      = g_data;
          last_d      = g_last;
          burst_cnt_d = burst_cnt_q + C_BURST_CW'(1);
          start_d     = 1'b1;
          state_d     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A done in the start cycle belongs to an earlier byte and is dropped.
        if (i_tx_done && !start_q) begin
          if (last_q || (burst_cnt_q == C_BURST_CW'(G_MAX_BURST))) begin
            state_d     = IDLE;
            rr_ptr_d    = grant_q;
            burst_cnt_d = '0;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; rr_ptr starts at the top so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(G_NB_REQ - 1);
      grant_q     <= '0;
      burst_cnt_q <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      data_q      <= data_d;
      last_q      <= last_d;
      start_q     <= start_d;
      err_q       <= err_d;
    end
  end

  assign o_tx_start  = start_q;
  assign o_tx_data   = data_q;
  assign o_grant_id  = grant_q;
  assign o_busy      = (state_q != IDLE);
  assign o_err_done  = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter G_NB_REQ, default 2, number of byte requesters (2..8).
REQ-002 SHALL have parameter G_DATA_WIDTH, default 8, UART byte width.
REQ-003 SHALL have parameter G_MAX_BURST, default 4, maximum bytes per grant (1..255).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port i_req_valid  in  G_NB_REQ  per-requester byte valid.
REQ-007 SHALL have port i_req_data  in  G_NB_REQ*G_DATA_WIDTH  per-requester byte; requester k occupies bits [k*W +: W].
REQ-008 SHALL have port i_req_last  in  G_NB_REQ  per-requester last byte of message.
REQ-009 SHALL have port o_req_ready  out  G_NB_REQ  byte accepted; one-hot or zero.
REQ-010 SHALL have port o_tx_start  out  1  one-cycle pulse that launches the UART serializer.
REQ-011 SHALL have port o_tx_data  out  G_DATA_WIDTH  byte to serialize; held stable until i_tx_done.
REQ-012 SHALL have port i_tx_busy  in  1  serializer busy.
REQ-013 SHALL have port i_tx_done  in  1  one-cycle pulse at end of stop bit.
REQ-014 SHALL have port o_grant_id  out  clog2(G_NB_REQ)  current or last grant index.
REQ-015 SHALL have port o_busy  out  1  high whenever state is not IDLE.
REQ-016 SHALL have port o_err_done  out  1  sticky flag for i_tx_done received outside WAIT_DONE.

Function
REQ-017 SHALL implement FSM states IDLE, SEND, WAIT_DONE.
REQ-018 IDLE: if any i_req_valid is high at cycle t, SHALL register the grant and be in SEND at t+1. Grant = first valid requester searching upward from (rr_ptr+1) mod G_NB_REQ.
REQ-019 SEND with i_req_valid[g]=1 and i_tx_busy=0: SHALL drive o_req_ready[g]=1 combinationally for that cycle, capture data/last, increment burst_cnt, and go to WAIT_DONE.
REQ-020 SHALL assert o_tx_start for exactly one cycle, the first WAIT_DONE cycle, with o_tx_data already valid. Latency from valid to o_tx_start = 2 cycles.
REQ-021 SEND with i_tx_busy=1: SHALL stall in SEND with o_req_ready=0.
REQ-022 SEND with i_req_valid[g]=0 (mid-burst underrun): SHALL go to IDLE with rr_ptr=g and burst_cnt=0.
REQ-023 WAIT_DONE: i_tx_done in the start cycle SHALL be ignored; it SHALL be accepted from the following cycle.
REQ-024 On accepted i_tx_done: if captured last=1 or burst_cnt==G_MAX_BURST, SHALL go to IDLE with rr_ptr=g and burst_cnt=0; otherwise SHALL go to SEND keeping the grant.
REQ-025 The rr_ptr wrap SHALL be modulo G_NB_REQ. A lone requester SHALL be regranted after one IDLE cycle.
REQ-026 Simultaneous valid from all requesters SHALL produce grants in strict rotation g, g+1, ... wrapping.
REQ-027 i_tx_done in IDLE or SEND SHALL set o_err_done, cause no state change, and o_err_done SHALL stay set until rst.
REQ-028 Requester inputs other than g SHALL never influence outputs while the grant is held.

Reset
REQ-029 While rst=1 at a clock edge:
- state=IDLE
- rr_ptr=G_NB_REQ-1, so requester 0 wins first
- burst_cnt=0
- o_req_ready=0, o_tx_start=0, o_tx_data=0, o_grant_id=0, o_busy=0, o_err_done=0
REQ-030 Reset asserted mid-burst SHALL abandon the byte in flight with no o_tx_start pulse after reset; a later i_tx_done SHALL set o_err_done.

Structure
REQ-031 Package uart_arb_pkg SHALL hold the FSM state enum (IDLE, SEND, WAIT_DONE) and the default constants for G_NB_REQ, G_DATA_WIDTH and G_MAX_BURST.
REQ-032 Combinational round-robin selection SHALL be a sub-module rr_priority_picker, with inputs valid vector and rr_ptr and outputs grant index and any_valid.
REQ-033 The target RTL size is 120-400 lines including the sub-module.

Verification
REQ-034 Single requester: req0 sends 0xA5 with last=1 -> o_tx_start 2 cycles after valid, o_tx_data=0xA5, o_req_ready[0] high 1 cycle, IDLE after i_tx_done.
REQ-035 Contention: req0 and req1 both send 3-byte messages at the same time -> req0 bytes 0x11,0x12,0x13 then req1 bytes 0x21,0x22,0x23, no interleave; next tie goes to req0 again only after req1.
REQ-036 Burst cap: G_MAX_BURST=4, req0 sends 6 bytes with req1 also valid -> 4 req0 bytes, then req1 message, then the remaining 2 req0 bytes.
REQ-037 Backpressure: i_tx_busy=1 for 10 cycles in SEND -> o_req_ready stays 0, no o_tx_start; byte goes out the cycle after busy falls.
REQ-038 Underrun and error: req1 drops valid mid-burst -> IDLE with rr_ptr=1; an i_tx_done pulse injected in IDLE -> o_err_done=1 and held until rst.
REQ-039 Reset mid-byte: rst for 1 cycle in WAIT_DONE -> all outputs at reset values next cycle; requester 0 wins the next tie.
